// File: rtl/usb_frame_streamer.sv
// rtl/usb_frame_streamer.sv - multi-channel frame capture streamed over an FT600-style 16-bit FIFO bridge
// Define USB_STREAM_HEADER_EN to prefix each frame with 0xA5A5 and the frame counter.
module usb_frame_streamer #(
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 128,
   parameter int CHANNELS = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start_sending,
   input  logic [CHANNELS*DATA_W-1:0]   sample_data,
   output logic [$clog2(DEPTH)-1:0]     sample_index,
   input  logic                         TXE_N,
   input  logic                         RXF_N,
   output logic                         OE_N,
   output logic                         RD_N,
   output logic                         WR_N,
   inout  wire  [DATA_W-1:0]            DATA,
   inout  wire  [DATA_W/8-1:0]          BE,
   output logic [DATA_W-1:0]            command,
   output logic                         command_valid,
   output logic                         busy,
   output logic                         frame_done
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int WCNT_W = $clog2(CHANNELS*DEPTH+2) + 1;
`ifdef USB_STREAM_HEADER_EN
   localparam int HDR = 2;
`else
   localparam int HDR = 0;
`endif
   localparam int TOTAL = CHANNELS*DEPTH + HDR;
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(TOTAL-1);

   typedef enum logic [1:0] {C_IDLE, C_CAPTURE, C_READY, C_WAIT_LOW} cap_state_t;
   typedef enum logic [2:0] {B_IDLE, B_OE, B_RD, B_LATCH, B_END, B_SEND} bus_state_t;

   cap_state_t cap_state, cap_next;
   bus_state_t bus_state, bus_next;

   logic [DATA_W-1:0] buffer [0:CHANNELS-1][0:DEPTH-1];
   logic              start_prev;
   logic              start_rise;
   logic [DATA_W-1:0] out_word;
   logic [WCNT_W-1:0] word_cnt;
   logic [WCNT_W-1:0] fetch_idx;
   logic [WCNT_W-1:0] pay;
   logic [CH_W-1:0]   fetch_ch;
   logic [IDX_W-1:0]  fetch_pos;
   logic [DATA_W-1:0] fetch_word;
   logic [15:0]       frame_cnt;
   logic              load_first;
   logic              accept;
   logic              send_done;

   assign start_rise = start_sending && !start_prev;
   assign busy       = !(cap_state == C_IDLE && bus_state == B_IDLE);
   assign DATA       = OE_N ? out_word : {DATA_W{1'bz}};
   assign BE         = OE_N ? {(DATA_W/8){1'b1}} : {(DATA_W/8){1'bz}};

   // ---------------- capture FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_state  <= C_IDLE;
         start_prev <= 1'b0;
      end else begin
         cap_state  <= cap_next;
         start_prev <= start_sending;
      end
   end

   always_comb begin
      cap_next = cap_state;
      case (cap_state)
         C_IDLE:     if (start_rise) cap_next = C_CAPTURE;
         C_CAPTURE:  if (sample_index == '0) cap_next = C_READY;
         C_READY:    if (send_done) cap_next = C_WAIT_LOW;
         C_WAIT_LOW: if (!start_sending) cap_next = C_IDLE;
         default:    cap_next = C_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         sample_index <= '0;
      else if (cap_state == C_IDLE && start_rise)
         sample_index <= IDX_W'(DEPTH-1);
      else if (cap_state == C_CAPTURE && sample_index != '0)
         sample_index <= sample_index - IDX_W'(1);
   end

   // Sample storage is deliberately never reset; it is rewritten on every capture.
   always_ff @(posedge clk) begin
      if (!reset && cap_state == C_CAPTURE)
         for (int c = 0; c < CHANNELS; c++)
            buffer[c][sample_index] <= sample_data[c*DATA_W +: DATA_W];
   end

   // ---------------- bus FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) bus_state <= B_IDLE;
      else       bus_state <= bus_next;
   end

   always_comb begin
      bus_next   = bus_state;
      load_first = 1'b0;
      accept     = 1'b0;
      send_done  = 1'b0;
      case (bus_state)
         B_IDLE: begin
            if (!RXF_N)
               bus_next = B_OE;
            else if (cap_state == C_READY) begin
               load_first = 1'b1;
               bus_next   = B_SEND;
            end
         end
         B_OE:    bus_next = B_RD;
         B_RD:    bus_next = B_LATCH;
         B_LATCH: bus_next = B_END;
         B_END:   bus_next = B_IDLE;
         B_SEND: begin
            if (!WR_N && !TXE_N) begin
               accept = 1'b1;
               if (word_cnt == LAST_WORD) begin
                  send_done = 1'b1;
                  bus_next  = B_IDLE;
               end
            end
         end
         default: bus_next = B_IDLE;
      endcase
   end

   // Word k maps to channel (k-HDR)/DEPTH, index DEPTH-1 - (k-HDR)%DEPTH.
   always_comb begin
      fetch_idx  = load_first ? '0 : word_cnt + WCNT_W'(1);
      pay        = fetch_idx - WCNT_W'(HDR);
      fetch_ch   = CH_W'(pay >> IDX_W);
      fetch_pos  = ~IDX_W'(pay);
      fetch_word = buffer[fetch_ch][fetch_pos];
`ifdef USB_STREAM_HEADER_EN
      if (fetch_idx == '0)
         fetch_word = DATA_W'(16'hA5A5);
      else if (fetch_idx == WCNT_W'(1))
         fetch_word = DATA_W'(frame_cnt);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         WR_N          <= 1'b1;
         OE_N          <= 1'b1;
         RD_N          <= 1'b1;
         out_word      <= '0;
         word_cnt      <= '0;
         frame_cnt     <= '0;
         command       <= '0;
         command_valid <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         command_valid <= 1'b0;
         frame_done    <= 1'b0;
         if (load_first) begin
            out_word <= fetch_word;
            word_cnt <= '0;
            WR_N     <= 1'b0;
         end
         if (accept && !send_done) begin
            out_word <= fetch_word;
            word_cnt <= word_cnt + WCNT_W'(1);
         end
         if (send_done) begin
            WR_N       <= 1'b1;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
         end
         if (bus_state == B_OE) OE_N <= 1'b0;
         if (bus_state == B_RD) RD_N <= 1'b0;
         if (bus_state == B_LATCH) begin
            command       <= DATA;
            command_valid <= 1'b1;
         end
         if (bus_state == B_END) begin
            OE_N <= 1'b1;
            RD_N <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_usb_frame_streamer.sv
// tb/tb_usb_frame_streamer.sv - directed self-checking bench for usb_frame_streamer (DEPTH=4, CHANNELS=2)
module tb_usb_frame_streamer;

   logic        clk;
   logic        reset;
   logic        start_sending;
   logic [31:0] sample_data;
   logic [1:0]  sample_index;
   logic        TXE_N;
   logic        RXF_N;
   logic        OE_N;
   logic        RD_N;
   logic        WR_N;
   wire  [15:0] DATA;
   wire  [1:0]  BE;
   logic [15:0] command;
   logic        command_valid;
   logic        busy;
   logic        frame_done;
   logic [15:0] host_word;

   usb_frame_streamer #(.DATA_W(16), .DEPTH(4), .CHANNELS(2)) dut (
      .clk(clk), .reset(reset), .start_sending(start_sending),
      .sample_data(sample_data), .sample_index(sample_index),
      .TXE_N(TXE_N), .RXF_N(RXF_N), .OE_N(OE_N), .RD_N(RD_N), .WR_N(WR_N),
      .DATA(DATA), .BE(BE), .command(command), .command_valid(command_valid),
      .busy(busy), .frame_done(frame_done)
   );

   assign sample_data = {16'h0010 + 16'(sample_index), 16'h0020 + 16'(sample_index)};
   assign DATA = OE_N ? 16'hzzzz : host_word;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] q[$];
   logic [15:0] exp_q[$];
   int wr_low, fd_cnt, oe_low, rd_low, cv_cnt, q_at_cv;
   logic [15:0] exp_fc = 16'd0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with inputs already set for the coming posedge.
   task automatic cycle();
      if (!WR_N && !TXE_N) q.push_back(DATA);
      if (!WR_N) wr_low++;
      if (frame_done) fd_cnt++;
      if (!OE_N) oe_low++;
      if (!RD_N) rd_low++;
      if (command_valid) begin
         cv_cnt++;
         q_at_cv = q.size();
      end
      @(negedge clk);
   endtask

   task automatic clear_mon();
      q.delete();
      wr_low = 0; fd_cnt = 0; oe_low = 0; rd_low = 0; cv_cnt = 0; q_at_cv = -1;
   endtask

   task automatic pulse_start();
      start_sending = 1'b1;
      cycle();
      cycle();
      start_sending = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (fd_cnt == 0 && n < 200) begin
         cycle();
         n++;
      end
      check_eq({tag, " done_within_bound"}, fd_cnt, 1);
   endtask

   task automatic check_frame(input string tag, input int extra_wr);
      logic [31:0] got;
      exp_q.delete();
`ifdef USB_STREAM_HEADER_EN
      exp_q.push_back(16'hA5A5);
      exp_q.push_back(exp_fc);
`endif
      for (int i = 3; i >= 0; i--) exp_q.push_back(16'h0020 + 16'(i));
      for (int i = 3; i >= 0; i--) exp_q.push_back(16'h0010 + 16'(i));
      check_eq({tag, " word_count"}, q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < q.size()) ? {16'h0, q[i]} : 32'hDEAD0000;
         check_eq($sformatf("%s word%0d", tag, i), got, {16'h0, exp_q[i]});
      end
      check_eq({tag, " wr_low_cycles"}, wr_low, exp_q.size() + extra_wr);
      check_eq({tag, " frame_done_pulses"}, fd_cnt, 1);
      exp_fc++;
   endtask

   initial begin
      int n;
      reset = 1'b1; start_sending = 1'b0; TXE_N = 1'b0; RXF_N = 1'b1; host_word = 16'h0;
      clear_mon();
      repeat (3) @(negedge clk);

      check_eq("reset WR_N", WR_N, 1);
      check_eq("reset OE_N", OE_N, 1);
      check_eq("reset RD_N", RD_N, 1);
      check_eq("reset command", command, 0);
      check_eq("reset command_valid", command_valid, 0);
      check_eq("reset frame_done", frame_done, 0);
      check_eq("reset busy", busy, 0);
      check_eq("reset sample_index", sample_index, 0);
      check_eq("reset DATA", DATA, 0);
      check_eq("reset BE", BE, 2'b11);
      reset = 1'b0;
      cycle();

      // plain frame, no backpressure
      clear_mon();
      pulse_start();
      check_eq("busy during capture", busy, 1);
      wait_done("frameA");
      check_frame("frameA", 0);
      cycle();

      // TXE_N high for 3 cycles while word 2 is presented
      clear_mon();
      pulse_start();
      n = 0;
      while (q.size() < 2 && n < 100) begin cycle(); n++; end
      check_eq("bp reached word2", q.size(), 2);
      TXE_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("bp hold WR_N c%0d", i), WR_N, 0);
         check_eq($sformatf("bp hold DATA c%0d", i), DATA, q.size() == 2 ? 16'h0021 + 16'h0 : 16'h0);
         cycle();
      end
      TXE_N = 1'b0;
      wait_done("frameB");
      check_frame("frameB", 3);
      cycle();

      // host read in idle
      clear_mon();
      host_word = 16'h1234;
      RXF_N = 1'b0;
      cycle();
      RXF_N = 1'b1;
      repeat (6) cycle();
      check_eq("read OE_N low cycles", oe_low, 3);
      check_eq("read RD_N low cycles", rd_low, 2);
      check_eq("read command", command, 16'h1234);
      check_eq("read command_valid pulses", cv_cnt, 1);
      check_eq("read no write", wr_low, 0);

      // read arrives in the same cycle the capture becomes READY
      clear_mon();
      host_word = 16'hBEEF;
      start_sending = 1'b1;
      cycle();
      cycle();
      start_sending = 1'b0;
      cycle(); cycle(); cycle();
      RXF_N = 1'b0;
      cycle();
      RXF_N = 1'b1;
      wait_done("frameC");
      check_eq("prio words before command_valid", q_at_cv, 0);
      check_eq("prio command", command, 16'hBEEF);
      check_frame("frameC", 0);
      cycle();

      // start held high: a single frame only
      clear_mon();
      start_sending = 1'b1;
      wait_done("frameD");
      check_frame("frameD", 0);
      repeat (30) cycle();
      check_eq("held-high frames", fd_cnt, 1);
      start_sending = 1'b0;
      repeat (2) cycle();

      // reset while word 3 is on the bus
      clear_mon();
      pulse_start();
      n = 0;
      while (q.size() < 3 && n < 100) begin cycle(); n++; end
      check_eq("abort reached word3", q.size(), 3);
      reset = 1'b1;
      cycle();
      check_eq("abort WR_N", WR_N, 1);
      check_eq("abort OE_N", OE_N, 1);
      check_eq("abort RD_N", RD_N, 1);
      check_eq("abort busy", busy, 0);
      check_eq("abort sample_index", sample_index, 0);
      check_eq("abort command", command, 0);
      check_eq("abort DATA", DATA, 0);
      reset = 1'b0;
      repeat (5) cycle();
      check_eq("abort frame_done pulses", fd_cnt, 0);
      exp_fc = 16'd0;

      // two separate pulses after reset: frame counter 0 then 1
      clear_mon();
      pulse_start();
      wait_done("frameF");
      check_frame("frameF", 0);
      cycle();
      clear_mon();
      pulse_start();
      wait_done("frameG");
      check_frame("frameG", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
